// File: rtl/prefix_eval_if.sv
// prefix_eval_if: request/result bundle between the prefix-expression block
// and the evaluator.
//   in_valid  : one-cycle strobe qualifying in_tokens
//   in_tokens : TOKENS packed 5-bit tokens, token 0 in the top bits
//   out_valid : one-cycle result strobe
//   out       : signed DW-bit result (0 when not valid or on error)
//   err       : error flag, meaningful only with out_valid
// master drives the request side, slave (the evaluator) drives the result.
interface prefix_eval_if #(
    parameter int TOKENS = 19,
    parameter int DW     = 32
);
    logic                  in_valid;
    logic [5*TOKENS-1:0]   in_tokens;
    logic                  out_valid;
    logic [DW-1:0]         out;
    logic                  err;

    modport master (output in_valid, in_tokens, input out_valid, out, err);
    modport slave  (input in_valid, in_tokens, output out_valid, out, err);
endinterface

// File: rtl/prefix_eval.sv
// prefix_eval: evaluates one prefix (Polish) expression of TOKENS 5-bit
// tokens with an internal operand stack, one token per cycle, scanning from
// the last token to the first. Fixed latency: strobe at T, result at T+20.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous reset, ACTIVE HIGH despite the name
//   bus   : prefix_eval_if.slave (in_valid/in_tokens in, out_valid/out/err out)
module prefix_eval #(
    parameter int TOKENS = 19,
    parameter int DEPTH  = 10,
    parameter int DW     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    prefix_eval_if.slave bus
);
    localparam int IW   = $clog2(TOKENS);
    localparam int DEPW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [5*TOKENS-1:0] tokens_q, tokens_d;
    logic [DEPW-1:0]     depth_q, depth_d;
    logic                err_flag_q, err_flag_d;
    logic [DW-1:0]       stack_q [DEPTH];
    logic [DW-1:0]       stack_d [DEPTH];
    logic                out_valid_q, out_valid_d;
    logic [DW-1:0]       out_q, out_d;
    logic                err_q, err_d;

    logic [4:0]          tok;
    logic [DW-1:0]       op_a, op_b, op_res;
    logic                div_zero;

    // Next-state computation: token decode, stack update and result capture.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tokens_d    = tokens_q;
        depth_d     = depth_q;
        err_flag_d  = err_flag_q;
        stack_d     = stack_q;
        out_valid_d = 1'b0;
        out_d       = '0;
        err_d       = 1'b0;
        // The token register is shifted right each cycle, so the token being
        // processed (index 18 first, then 17, ...) always sits in the low bits.
        tok         = tokens_q[4:0];
        op_a        = '0;
        op_b        = '0;
        op_res      = '0;
        div_zero    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    tokens_d   = bus.in_tokens;
                    depth_d    = '0;
                    err_flag_d = 1'b0;
                    idx_d      = IW'(TOKENS - 1);
                    state_d    = S_EVAL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EVAL: begin
                tokens_d = tokens_q >> 5;
                if (tok[4] == 1'b0) begin
                    // Operand push; overflow drops the value and flags.
                    if (depth_q == DEPW'(DEPTH)) begin
                        err_flag_d = 1'b1;
                    end else begin
                        stack_d[depth_q] = {{(DW-4){1'b0}}, tok[3:0]};
                        depth_d          = depth_q + DEPW'(1);
                    end
                end else if (tok == 5'b11111) begin
                    depth_d = depth_q;
                end else if (tok[3:2] == 2'b00) begin
                    if (depth_q < DEPW'(2)) begin
                        err_flag_d = 1'b1;
                    end else begin
                        op_a = stack_q[depth_q - DEPW'(1)];
                        op_b = stack_q[depth_q - DEPW'(2)];
                        case (tok[1:0])
                            2'b00: op_res = op_a + op_b;
                            2'b01: op_res = op_a - op_b;
                            2'b10: op_res = op_a * op_b;
                            2'b11: begin
                                if (op_b == '0) begin
                                    div_zero = 1'b1;
                                    op_res   = '0;
                                end else if (op_b == '1) begin
                                    // a / -1 is a negation; wraps -2^31 onto itself
                                    // without relying on signed-divide overflow.
                                    op_res = '0 - op_a;
                                end else begin
                                    op_res = $signed(op_a) / $signed(op_b);
                                end
                            end
                            default: op_res = '0;
                        endcase
                        stack_d[depth_q - DEPW'(2)] = op_res;
                        depth_d                     = depth_q - DEPW'(1);
                        err_flag_d                  = err_flag_q | div_zero;
                    end
                end else begin
                    err_flag_d = 1'b1;
                end

                if (idx_q == '0) begin
                    // Last token: fold in the final depth check and capture
                    // the result so outputs change exactly on entry to OUT.
                    err_flag_d  = err_flag_d | (depth_d != DEPW'(1));
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                    err_d       = err_flag_d;
                    out_d       = err_flag_d ? '0 : stack_d[0];
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            tokens_q    <= '0;
            depth_q     <= '0;
            err_flag_q  <= 1'b0;
            stack_q     <= '{default: '0};
            out_valid_q <= 1'b0;
            out_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tokens_q    <= tokens_d;
            depth_q     <= depth_d;
            err_flag_q  <= err_flag_d;
            stack_q     <= stack_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_prefix_eval.sv
// tb_prefix_eval: directed vectors with a scoreboard. Each issued expression
// pushes its expected result and arrival cycle; a negedge monitor pops and
// compares whenever out_valid is seen, and checks outputs are 0 otherwise.
module tb_prefix_eval;
    localparam logic [4:0] ADD = 5'h10;
    localparam logic [4:0] SUB = 5'h11;
    localparam logic [4:0] MUL = 5'h12;
    localparam logic [4:0] DIV = 5'h13;
    localparam logic [4:0] ILL = 5'h14;
    localparam logic [4:0] PAD = 5'h1F;

    typedef struct {
        int          cyc;
        logic [31:0] o;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    prefix_eval_if bus_if ();

    prefix_eval dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [94:0] pk(input logic [4:0] t0, input logic [4:0] t1,
                                       input logic [4:0] t2, input logic [4:0] t3,
                                       input logic [4:0] t4);
        return {t0, t1, t2, t3, t4, {14{PAD}}};
    endfunction

    // Drive one in_valid cycle starting now (just after a rising edge).
    task automatic send(input logic [94:0] v, input bit expect_res,
                        input logic [31:0] eo, input logic ee);
        exp_t x;
        bus_if.in_tokens = v;
        bus_if.in_valid  = 1'b1;
        if (expect_res) begin
            x.cyc = cyc + 20;
            x.o   = eo;
            x.e   = ee;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare results against the scoreboard, check idle outputs.
    always @(negedge clk) begin
        exp_t e;
        if (bus_if.out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: cycle %0d out %h err %b, required no out_valid",
                         cyc, bus_if.out, bus_if.err);
            end else begin
                e = sb.pop_front();
                if (cyc != e.cyc || bus_if.out !== e.o || bus_if.err !== e.e) begin
                    errors++;
                    $display("FAIL result: cycle %0d out %h err %b, required cycle %0d out %h err %b",
                             cyc, bus_if.out, bus_if.err, e.cyc, e.o, e.e);
                end
            end
        end else begin
            checks++;
            if (bus_if.out !== 32'h0 || bus_if.err !== 1'b0 || bus_if.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs: cycle %0d valid %b out %h err %b, required 0 0 0",
                         cyc, bus_if.out_valid, bus_if.out, bus_if.err);
            end
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_result: cycle %0d no out_valid, required at cycle %0d out %h err %b",
                         cyc, sb[0].cyc, sb[0].o, sb[0].e);
                e = sb.pop_front();
            end
        end
    end

    initial begin
        logic [94:0] v;
        int n;
        rst_n            = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_tokens = '0;
        gap(3);
        rst_n = 1'b0;

        // Reset state
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.out !== 32'h0 || bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid %b out %h err %b, required 0 0 0",
                     bus_if.out_valid, bus_if.out, bus_if.err);
        end

        // - * 3 4 5 = 12 - 5 = 7
        send(pk(SUB, MUL, 5'd3, 5'd4, 5'd5), 1'b1, 32'd7, 1'b0);
        gap(20);
        // / - 0 7 2 = -7 / 2 = -3
        send(pk(DIV, SUB, 5'd0, 5'd7, 5'd2), 1'b1, 32'hFFFF_FFFD, 1'b0);
        gap(20);
        // / 7 0 : divide by zero
        send(pk(DIV, 5'd7, 5'd0, PAD, PAD), 1'b1, 32'h0, 1'b1);
        gap(20);
        // - 0 1 = -1 (wrap)
        send(pk(SUB, 5'd0, 5'd1, PAD, PAD), 1'b1, 32'hFFFF_FFFF, 1'b0);
        gap(20);
        // 9 x mul then 10 x 15 = 15^10 mod 2^32
        v = '0;
        for (int i = 0; i < 19; i++) v[94-5*i -: 5] = (i < 9) ? MUL : 5'd15;
        send(v, 1'b1, 32'd1124772961, 1'b0);
        gap(20);
        // + 3 : underflow
        send(pk(ADD, 5'd3, PAD, PAD, PAD), 1'b1, 32'h0, 1'b1);
        gap(20);
        // 3 4 : final depth 2
        send(pk(5'd3, 5'd4, PAD, PAD, PAD), 1'b1, 32'h0, 1'b1);
        gap(20);
        // 19 x operand 1 : overflow
        v = '0;
        for (int i = 0; i < 19; i++) v[94-5*i -: 5] = 5'd1;
        send(v, 1'b1, 32'h0, 1'b1);
        gap(20);
        // + 3 <illegal> 4 : illegal token
        send(pk(ADD, 5'd3, ILL, 5'd4, PAD), 1'b1, 32'h0, 1'b1);
        gap(20);

        // Ignored strobes at T+5 and T+20, accepted at T+21
        send(pk(ADD, 5'd2, 5'd9, PAD, PAD), 1'b1, 32'd11, 1'b0);     // T
        gap(4);
        send(pk(MUL, 5'd6, 5'd6, PAD, PAD), 1'b0, 32'h0, 1'b0);      // T+5
        gap(14);
        send(pk(SUB, 5'd1, 5'd8, PAD, PAD), 1'b0, 32'h0, 1'b0);      // T+20
        send(pk(MUL, 5'd3, 5'd5, PAD, PAD), 1'b1, 32'd15, 1'b0);     // T+21
        gap(20);

        // Reset mid-EVAL at T+10: no result for the aborted expression
        send(pk(ADD, 5'd1, 5'd1, PAD, PAD), 1'b0, 32'h0, 1'b0);      // T
        gap(9);
        rst_n = 1'b1;                                                // T+10
        gap(1);
        rst_n = 1'b0;
        // Clean stack after reset: * 5 6 = 30
        send(pk(MUL, 5'd5, 5'd6, PAD, PAD), 1'b1, 32'd30, 1'b0);
        gap(20);

        n = 0;
        while (sb.size() > 0 && n < 100) begin
            gap(1);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        gap(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prefix_eval.md
# prefix_eval

Evaluator stage directly downstream of the prefix-expression block. It takes one 95-bit vector of 19 packed 5-bit tokens in prefix (Polish) order, evaluates it with an internal operand stack at one token per cycle, and returns a 32-bit signed result with an error flag. Latency is fixed so the top-level sequencer can schedule the next expression without extra handshaking.

## Interface
- `TOKENS`, 19: tokens per expression (fixed by the upstream 95-bit bus).
- `DEPTH`, 10: operand stack entries.
- `DW`, 32: result and stack width, two's complement.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-high reset; the name is kept for codebase consistency.
- `in_valid`  in  1  one-cycle strobe; `in_tokens` is valid in that cycle.
- `in_tokens`  in  95  token i at bits [94-5i : 90-5i]; token 0 is the leftmost prefix token.
- `out_valid`  out  1  one-cycle result strobe.
- `out`  out  32  signed result; 0 whenever `out_valid`=0 or `err`=1.
- `err`  out  1  malformed expression or divide by zero; valid only with `out_valid`.

## Operation
- Token encoding:
  - 0xxxx: operand, unsigned value 0..15, zero-extended to 32 bits.
  - 10000: add. 10001: sub. 10010: mul. 10011: div.
  - 11111: pad, with no stack effect.
  - Any other 1xxxx: illegal token, sets `err`.
- FSM states: IDLE, EVAL, OUT.
  - IDLE: when `in_valid`=1, latch `in_tokens`, clear the stack and the error flag, set the index to 18, and go to EVAL.
  - EVAL: process one token per cycle, indices 18 down to 0. After index 0, go to OUT.
  - OUT: drive `out_valid`=1 for one cycle, then return to IDLE.
- Token processing:
  - Operand: push. A push at depth `DEPTH` sets the sticky error flag and drops the value.
  - Operator: needs depth ≥ 2, otherwise set the sticky error flag and leave the stack unchanged. Pop a (top), then pop b, then push (a op b).
  - sub is a−b. div is a/b, truncated toward zero. b=0 sets the error flag and pushes 0. −2^31 / −1 yields −2^31.
  - add, sub and mul wrap modulo 2^32; the low 32 bits of the product are kept.
- Final check: when stack depth ≠ 1 at the end of EVAL, set the error flag.
- In OUT: `err` = error flag. `out` = stack top if no error, else 0.
- Once the error flag is set, evaluation continues but the result is discarded.
- `in_valid` in EVAL or OUT is ignored. It is not queued and has no effect on the expression in flight.

## Timing
- `in_valid` sampled at cycle T, in IDLE.
- EVAL runs T+1..T+19. `out_valid`=1 in cycle T+20 only.
- Earliest next accepted `in_valid` is T+21.
- Reset values: `out_valid`=0, `out`=0, `err`=0, FSM=IDLE, stack depth 0.
- Reset asserted in any cycle, including mid-EVAL or OUT:
  - The next cycle is IDLE with all outputs 0.
  - The aborted expression produces no `out_valid`.
  - `in_valid` in the cycle after reset deasserts is accepted.
- `out` and `err` are registered and change only on entry to OUT or on exit from it.

## Test plan
- `- * 3 4 5`, then 14 pads; `in_valid` at T → `out_valid` at exactly T+20, `out`=7, `err`=0; `out_valid` low at T+19 and T+21.
- `/ - 0 7 2`, then pads → `out`=32'hFFFFFFFD (−3, truncation toward zero), `err`=0. `/ 7 0`, then pads → `out`=0, `err`=1.
- 9 × mul followed by 10 × operand 15 → `out`=1124772961 (15^10 mod 2^32), `err`=0.
- Malformed expressions, each → `out`=0, `err`=1:
  - `+ 3`, then pads (underflow).
  - `3 4`, then pads (final depth 2).
  - 19 × operand 1 (overflow).
  - Token 10100 anywhere (illegal).
- Second `in_valid` with a different expression at T+5 and at T+20 → both ignored; only the first result appears at T+20. A new `in_valid` at T+21 is accepted, with its result at T+41.
- `rst_n`=1 for one cycle at T+10 → no `out_valid` for that expression, all outputs 0. A new expression after reset evaluates correctly with a clean stack.
